muldiv_hilo: RTL and testbench

Iterative integer multiply/divide unit with architectural HI/LO registers, directly downstream of the register file. It consumes the two register read ports (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. MFHI/MFLO read the Hi/Lo outputs directly. Uses one shift-add / restoring-divide datapath over 32 iterations with a start/busy/done handshake to the control unit.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_hilo_if.sv | 25 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_hilo.sv | 166 ++++++++++++++++
 tb/tb_muldiv_hilo.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_hilo_if.sv
// Control-unit side of the multiply/divide unit.
// Handshake: Start is sampled only while Busy=0; Done pulses for one cycle when Hi/Lo take a mul/div result.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, OperandA, OperandB,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, OperandA, OperandB,
    output Busy, Done, DivZero, Hi, Lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// divide step on the {acc_hi, acc_lo} accumulator pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_fits;
  logic [WIDTH:0]   div_rem;
  logic             unused_rem_msb;

  // Multiply: acc_lo holds the unconsumed multiplier bits, LSB first.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
  assign div_fits  = ~div_diff[WIDTH+1];
  assign div_rem   = div_fits ? div_diff[WIDTH:0] : div_shift;
  // The remainder stays below the divisor, so its top bit is always zero.
  assign unused_rem_msb = div_rem[WIDTH];

  always_comb begin
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (is_div) begin
      nxt_hi = div_rem[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_fits};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Magnitudes are iterated for WIDTH cycles, then signs are fixed in one cycle.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic          Clock,
  input  logic          Reset,
  muldiv_hilo_if.slave  bus,
  output state_e        dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] orig_a_q, orig_a_d;
  logic [2:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic               start_signed, start_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               run_signed, run_div;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign start_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
  assign start_div    = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
  assign abs_a = (start_signed && bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
  assign abs_b = (start_signed && bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;

  assign run_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign run_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (run_div),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .opnd   (opnd_q),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // Most-negative / -1 wraps naturally: the magnitude quotient negates to itself.
  assign product  = {acc_hi_q, acc_lo_q};
  assign prod_fix = (run_signed && (sign_a_q ^ sign_b_q)) ? -product : product;
  assign quo_fix  = (run_signed && (sign_a_q ^ sign_b_q)) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = (run_signed && sign_a_q) ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    orig_a_d   = orig_a_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    b_zero_d   = b_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          case (bus.Op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              sign_a_d = start_signed && bus.OperandA[WIDTH-1];
              sign_b_d = start_signed && bus.OperandB[WIDTH-1];
              acc_hi_d = '0;
              acc_lo_d = start_div ? abs_a : abs_b;
              opnd_d   = start_div ? abs_b : abs_a;
              op_d     = bus.Op;
              b_zero_d = (bus.OperandB == '0);
              orig_a_d = bus.OperandA;
              cnt_d    = '0;
              state_d  = RUN;
            end
            OP_MTHI: hi_d = bus.OperandA;
            OP_MTLO: lo_d = bus.OperandA;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = FIX;
      end
      FIX: begin
        if (run_div && b_zero_q) begin
          hi_d = orig_a_q;
          lo_d = '1;
        end else if (run_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d     = 1'b1;
        div_zero_d = run_div && b_zero_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      orig_a_q   <= '0;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      orig_a_q   <= orig_a_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      b_zero_q   <= b_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.Busy    = (state_q != IDLE);
  assign bus.Done    = done_q;
  assign bus.DivZero = div_zero_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: directed corner cases from the datasheet plus random
// traffic scored against a plain-arithmetic model of HI/LO.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic   Clock;
  logic   Reset;
  state_e dbg_state;

  muldiv_hilo_if #(.WIDTH(32)) bus ();

  muldiv_hilo #(.WIDTH(32), .CNT_W(5)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model: results from plain integer arithmetic
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = model_hi;
    lo = model_lo;
    case (op)
      OP_MULT: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      OP_MULTU: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (op == OP_DIV) begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      3:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // driver: one mul/div from Start to Done, optional junk on the inputs while busy
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dz,
                        input bit noise);
    int busy_cnt;
    int lat;
    bit got_done;
    exp_q.push_back(e_hi);
    exp_q.push_back(e_lo);
    exp_q.push_back(32'(e_dz));
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
    @(posedge Clock); #1;
    busy_cnt = bus.Busy ? 1 : 0;
    lat = 0;
    got_done = 1'b0;
    bus.Start = 1'b0;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      if (noise) begin
        bus.Start = 1'($urandom_range(0, 1));
        bus.Op = 3'($urandom_range(0, 7));
        bus.OperandA = $urandom;
        bus.OperandB = $urandom;
      end
      @(posedge Clock); #1;
      if (bus.Busy) busy_cnt++;
      if (k == 16) begin
        check_val("hold_hi", bus.Hi, model_hi);
        check_val("hold_lo", bus.Lo, model_lo);
      end
      if (bus.Done) begin
        got_done = 1'b1;
        lat = k;
      end
    end
    bus.Start = 1'b0;
    check_val("latency", 32'(lat), 32'd33);
    check_val("busy_cycles", 32'(busy_cnt), 32'd33);
    check_val("result_hi", bus.Hi, exp_q.pop_front());
    check_val("result_lo", bus.Lo, exp_q.pop_front());
    check_val("div_zero", 32'(bus.DivZero), exp_q.pop_front());
    model_hi = e_hi;
    model_lo = e_lo;
    @(posedge Clock); #1;
    check_val("done_pulse", 32'(bus.Done), 32'd0);
    check_val("dz_pulse", 32'(bus.DivZero), 32'd0);
  endtask

  task automatic move_op(input logic [2:0] op, input logic [31:0] a);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = $urandom;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    if (op == OP_MTHI) model_hi = a;
    if (op == OP_MTLO) model_lo = a;
    check_val("move_hi", bus.Hi, model_hi);
    check_val("move_lo", bus.Lo, model_lo);
    check_val("move_busy", 32'(bus.Busy), 32'd0);
    check_val("move_done", 32'(bus.Done), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    check_val({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    check_val({tag, "_done"}, 32'(bus.Done), 32'd0);
    check_val({tag, "_dz"}, 32'(bus.DivZero), 32'd0);
    check_val({tag, "_hi"}, bus.Hi, 32'd0);
    check_val({tag, "_lo"}, bus.Lo, 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    logic [31:0] a, b, e_hi, e_lo;
    logic [2:0]  op;
    logic        e_dz;

    bus.Start = 1'b0; bus.Op = OP_MULT; bus.OperandA = '0; bus.OperandB = '0;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    reset_checks("reset");
    @(negedge Clock);
    Reset = 1'b0;

    // directed corners with hand-derived results
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(OP_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFEF, 32'd0,        32'hFFFF_FFEF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);

    // moves on consecutive edges, then an undefined op
    move_op(OP_MTHI, 32'h1234_5678);
    move_op(OP_MTLO, 32'h9ABC_DEF0);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = 3'd6; bus.OperandA = 32'hDEAD_BEEF;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    check_val("undef_busy", 32'(bus.Busy), 32'd0);
    check_val("undef_state", 32'(dbg_state), 32'(IDLE));
    check_val("undef_hi", bus.Hi, model_hi);
    check_val("undef_lo", bus.Lo, model_lo);

    // MTHI issued during RUN must be ignored
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd5; bus.OperandB = 32'd6;
    @(posedge Clock); #1;
    bus.Op = OP_MTHI; bus.OperandA = 32'hCAFE_F00D;
    repeat (3) @(posedge Clock);
    #1;
    bus.Start = 1'b0;
    check_val("mthi_in_run_hi", bus.Hi, model_hi);
    repeat (40) @(posedge Clock);
    #1;
    model_hi = 32'd0;
    model_lo = 32'd30;
    check_val("mthi_in_run_res_hi", bus.Hi, model_hi);
    check_val("mthi_in_run_res_lo", bus.Lo, model_lo);

    // reset in the middle of a divide
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = $urandom; bus.OperandB = 32'd3;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    repeat (11) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    reset_checks("abort");
    @(negedge Clock);
    Reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    run_op(OP_MULT, 32'd12, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFC4, 1'b0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 9))
        0: move_op(OP_MTHI, rand_word());
        1: move_op(OP_MTLO, rand_word());
        default: begin
          op = 3'($urandom_range(0, 3));
          a = rand_word();
          b = rand_word();
          model(op, a, b, e_hi, e_lo, e_dz);
          run_op(op, a, b, e_hi, e_lo, e_dz, bit'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
